piece_move_ctrl: RTL

PIECE_MOVE_CTRL -- requirements
Module: piece_move_ctrl

---
 rtl/tetris_pkg.sv | 23 ++
 rtl/move_req_latch.sv | 39 +++
 rtl/piece_move_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared encodings for the piece movement controller: game modes, move sources, controller states.
package tetris_pkg;

  localparam logic [2:0] MODE_PLAY = 3'd1;
  localparam int NUM_SRC = 5;

  // Enum value doubles as the pending-bit index; lower index = higher priority.
  typedef enum logic [2:0] {
    SRC_GRAVITY = 3'd0,
    SRC_LEFT    = 3'd1,
    SRC_RIGHT   = 3'd2,
    SRC_ROTATE  = 3'd3,
    SRC_DOWN    = 3'd4,
    SRC_NONE    = 3'd7
  } move_src_t;

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_IDLE   = 2'd1,
    ST_TEST   = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/move_req_latch.sv
// Captures single-cycle move events as pending bits and presents the highest-priority one.
module move_req_latch
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [NUM_SRC-1:0] ev,
  input  logic               issue,
  output logic               req_vld,
  output move_src_t          req_src
);

  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] grant;

  // Lowest set bit wins: gravity > left > right > rotate > down.
  assign grant   = pend & (~pend + NUM_SRC'(1));
  assign req_vld = |pend;

  always_comb begin
    req_src = SRC_NONE;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) req_src = move_src_t'(3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (clr) begin
      pend <= '0;
    end else begin
      // A repeat of a source that is still pending is dropped, even in its issue cycle.
      pend <= (pend & ~(issue ? grant : '0)) | (ev & ~pend);
    end
  end

endmodule

// File: rtl/piece_move_ctrl.sv
// Falling-piece move controller: queues move events, sends candidates to a collision checker, commits or locks.
// Optional wall kick on rejected rotation when PIECE_MOVE_WALL_KICK_EN is defined.
module piece_move_ctrl
  import tetris_pkg::*;
#(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int X_W     = 4,
  parameter int Y_W     = 5,
  parameter int ROT_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             spawn,
  input  logic [X_W-1:0]   spawn_x,
  input  logic [Y_W-1:0]   spawn_y,
  input  logic             gravity_tick,
  input  logic             btn_left_en,
  input  logic             btn_right_en,
  input  logic             btn_rotate_en,
  input  logic             btn_down_en,
  output logic             test_valid,
  output logic [X_W-1:0]   test_pos_x,
  output logic [Y_W-1:0]   test_pos_y,
  output logic [ROT_W-1:0] test_rot,
  input  logic             chk_done,
  input  logic             chk_ok,
  output logic [X_W-1:0]   cur_pos_x,
  output logic [Y_W-1:0]   cur_pos_y,
  output logic [ROT_W-1:0] cur_rot,
  output logic             lock_pulse
);

  localparam logic [X_W-1:0] X_LAST = X_W'(BOARD_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(BOARD_H - 1);

  ctrl_state_t      state, state_n;
  move_src_t        src_q, src_n, req_src;
  logic             req_vld, issue, play, lock_n;
  logic [X_W-1:0]   cur_x_n, test_x_n, cand_x;
  logic [Y_W-1:0]   cur_y_n, test_y_n, cand_y;
  logic [ROT_W-1:0] cur_rot_n, test_rot_n, cand_rot;
  logic             cand_ok, cand_land;
`ifdef PIECE_MOVE_WALL_KICK_EN
  logic [1:0]       kick_q, kick_n;
`endif

  assign play       = (mode == MODE_PLAY);
  assign test_valid = (state == ST_TEST);

  move_req_latch u_req (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (spawn | ~play),
    .ev      ((state == ST_LOCKED) ? '0 :
              {btn_down_en, btn_rotate_en, btn_right_en, btn_left_en, gravity_tick}),
    .issue   (issue),
    .req_vld (req_vld),
    .req_src (req_src)
  );

  always_comb begin
    cand_x    = cur_pos_x;
    cand_y    = cur_pos_y;
    cand_rot  = cur_rot;
    cand_ok   = 1'b1;
    cand_land = 1'b0;
    case (req_src)
      SRC_GRAVITY, SRC_DOWN: begin
        if (cur_pos_y == Y_LAST) begin
          cand_ok   = 1'b0;
          cand_land = 1'b1;
        end else begin
          cand_y = cur_pos_y + Y_W'(1);
        end
      end
      SRC_LEFT:   if (cur_pos_x == '0) cand_ok = 1'b0; else cand_x = cur_pos_x - X_W'(1);
      SRC_RIGHT:  if (cur_pos_x == X_LAST) cand_ok = 1'b0; else cand_x = cur_pos_x + X_W'(1);
      SRC_ROTATE: cand_rot = cur_rot + ROT_W'(1);
      default:    cand_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    src_n      = src_q;
    cur_x_n    = cur_pos_x;
    cur_y_n    = cur_pos_y;
    cur_rot_n  = cur_rot;
    test_x_n   = test_pos_x;
    test_y_n   = test_pos_y;
    test_rot_n = test_rot;
    lock_n     = 1'b0;
    issue      = 1'b0;
`ifdef PIECE_MOVE_WALL_KICK_EN
    kick_n     = kick_q;
`endif
    if (spawn) begin
      state_n   = ST_IDLE;
      cur_x_n   = spawn_x;
      cur_y_n   = spawn_y;
      cur_rot_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (play && req_vld) begin
            issue = 1'b1;
            src_n = req_src;
            if (cand_ok) begin
              state_n    = ST_TEST;
              test_x_n   = cand_x;
              test_y_n   = cand_y;
              test_rot_n = cand_rot;
`ifdef PIECE_MOVE_WALL_KICK_EN
              kick_n     = 2'd0;
`endif
            end else if (cand_land) begin
              lock_n  = 1'b1;
              state_n = ST_LOCKED;
            end
          end
        end
        ST_TEST: begin
          if (!play) begin
            state_n = ST_IDLE;
          end else if (chk_done) begin
            if (chk_ok) begin
              state_n   = ST_IDLE;
              cur_x_n   = test_pos_x;
              cur_y_n   = test_pos_y;
              cur_rot_n = test_rot;
            end else if (src_q == SRC_GRAVITY || src_q == SRC_DOWN) begin
              lock_n  = 1'b1;
              state_n = ST_LOCKED;
            end else begin
              state_n = ST_IDLE;
`ifdef PIECE_MOVE_WALL_KICK_EN
              // Retry the same rotation one column left, then one column right.
              if (src_q == SRC_ROTATE) begin
                if (kick_q == 2'd0 && cur_pos_x != '0) begin
                  state_n  = ST_TEST;
                  test_x_n = cur_pos_x - X_W'(1);
                  kick_n   = 2'd1;
                end else if (kick_q != 2'd2 && cur_pos_x != X_LAST) begin
                  state_n  = ST_TEST;
                  test_x_n = cur_pos_x + X_W'(1);
                  kick_n   = 2'd2;
                end
              end
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_LOCKED;
      src_q      <= SRC_NONE;
      cur_pos_x  <= '0;
      cur_pos_y  <= '0;
      cur_rot    <= '0;
      test_pos_x <= '0;
      test_pos_y <= '0;
      test_rot   <= '0;
      lock_pulse <= 1'b0;
`ifdef PIECE_MOVE_WALL_KICK_EN
      kick_q     <= 2'd0;
`endif
    end else begin
      state      <= state_n;
      src_q      <= src_n;
      cur_pos_x  <= cur_x_n;
      cur_pos_y  <= cur_y_n;
      cur_rot    <= cur_rot_n;
      test_pos_x <= test_x_n;
      test_pos_y <= test_y_n;
      test_rot   <= test_rot_n;
      lock_pulse <= lock_n;
`ifdef PIECE_MOVE_WALL_KICK_EN
      kick_q     <= kick_n;
`endif
    end
  end

endmodule
